// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing with running pixel coordinates.
// Sync/visible decode is registered from the next x/y so it lines up with x/y.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS0 = H_VISIBLE + H_FRONT;
    localparam int VS0 = V_VISIBLE + V_FRONT;

    logic [3:0] div;
    logic       tick, x_end, y_end;
    logic [9:0] x_n, y_n;

    always_comb begin
        tick  = div == 4'(CLK_DIV - 1);
        x_end = x == 10'(H_TOTAL - 1);
        y_end = y == 10'(V_TOTAL - 1);
        x_n   = x_end ? 10'd0 : x + 10'd1;
        y_n   = x_end ? (y_end ? 10'd0 : y + 10'd1) : y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            p_tick      <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= tick ? 4'd0 : div + 4'd1;
            p_tick      <= tick;
            frame_start <= tick && x_end && y_end;
            if (tick) begin
                x        <= x_n;
                y        <= y_n;
                hsync    <= !(x_n >= 10'(HS0) && x_n < 10'(HS0 + H_SYNC));
                vsync    <= !(y_n >= 10'(VS0) && y_n < 10'(VS0 + V_SYNC));
                video_on <= x_n < 10'(H_VISIBLE) && y_n < 10'(V_VISIBLE);
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: closed-form timing model scoreboard over three parameterisations.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       d_pt, d_hs, d_vs, d_vo, d_fs, s_pt, s_hs, s_vs, s_vo, s_fs, o_pt, o_hs, o_vs, o_vo, o_fs;
    logic [9:0] d_x, d_y, s_x, s_y, o_x, o_y;

    vga_sync_gen dut_d (.clk(clk), .rst_n(rst_n), .p_tick(d_pt), .x(d_x), .y(d_y),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_vo), .frame_start(d_fs));
    vga_sync_gen #(.CLK_DIV(4), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) dut_s (.clk(clk), .rst_n(rst_n),
        .p_tick(s_pt), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .frame_start(s_fs));
    vga_sync_gen #(.CLK_DIV(1)) dut_o (.clk(clk), .rst_n(rst_n), .p_tick(o_pt), .x(o_x), .y(o_y),
        .hsync(o_hs), .vsync(o_vs), .video_on(o_vo), .frame_start(o_fs));

    int compared = 0, mismatched = 0;
    int n = 0;
    logic [24:0] sb[$];
    bit counting = 0;
    int hlow = 0, sframes = 0, svis = 0, ofs = 0;

    // Expected outputs after n clk edges since reset release, from tick count alone.
    function automatic logic [24:0] model(int n, int cd, int hv, int hf, int hs, int hb,
                                          int vv, int vf, int vs, int vb);
        int t, p, ht, vt, xx, yy;
        logic tk;
        if (n == 0) return {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        t  = n / cd;
        p  = t % (ht * vt);
        xx = p % ht;
        yy = p / ht;
        tk = (n % cd) == 0;
        return {tk, 10'(xx), 10'(yy), !(xx >= hv + hf && xx < hv + hf + hs),
                !(yy >= vv + vf && yy < vv + vf + vs), t > 0 && xx < hv && yy < vv,
                tk && t > 0 && p == 0};
    endfunction

    task automatic cmp(string tag, logic [24:0] obs, logic [24:0] e);
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, e);
        end
    endtask

    task automatic push_all();
        sb.push_back(model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        sb.push_back(model(n, 4, 16, 2, 3, 2, 8, 1, 2, 2));
        sb.push_back(model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33));
    endtask

    task automatic check_all();
        cmp("default", {d_pt, d_x, d_y, d_hs, d_vs, d_vo, d_fs}, sb.pop_front());
        cmp("small", {s_pt, s_x, s_y, s_hs, s_vs, s_vo, s_fs}, sb.pop_front());
        cmp("div1", {o_pt, o_x, o_y, o_hs, o_vs, o_vo, o_fs}, sb.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        push_all();
        @(negedge clk);
        check_all();
        if (counting) begin
            if (d_pt && !d_hs && d_y == 10'd0) hlow++;
            if (s_fs) sframes++;
            if (sframes == 1 && s_pt && s_vo) svis++;
            if (o_fs) ofs++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (10) step();
        rst_n = 1'b1;
        counting = 1;
        repeat (3400) step();
        counting = 0;
        compared++;
        assert (hlow === 96) else begin
            mismatched++;
            $error("FAIL hsync_low_ticks observed=%0d expected=96", hlow);
        end
        compared++;
        assert (sframes === 2) else begin
            mismatched++;
            $error("FAIL frame_start_count observed=%0d expected=2", sframes);
        end
        compared++;
        assert (svis === 16 * 8) else begin
            mismatched++;
            $error("FAIL visible_ticks observed=%0d expected=%0d", svis, 16 * 8);
        end
        compared++;
        assert (ofs === 0) else begin
            mismatched++;
            $error("FAIL div1_no_frame_start observed=%0d expected=0", ofs);
        end
        // Asynchronous reset mid-line, then re-run to a mid-frame point and reset again.
        for (int k = 0; k < 2; k++) begin
            #2 rst_n = 1'b0;
            #1 n = 0;
            push_all();
            check_all();
            repeat (4) step();
            rst_n = 1'b1;
            repeat (k == 0 ? 540 : 300) step();
            if (k == 0) begin
                compared++;
                assert ({s_x, s_y} === {10'd20, 10'd5}) else begin
                    mismatched++;
                    $error("FAIL pre_reset_position observed=%0d,%0d expected=20,5", s_x, s_y);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
